// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
// Imported by the fetch queue, the fetch unit and its interface users.
package fetch_pkg;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP_INST         = 32'h0000_0013;

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } fetch_state_e;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
    } fetch_entry_t;

    function automatic logic is_aligned(input logic [31:0] addr);
        return (addr[1:0] == 2'b00);
    endfunction

endpackage

// File: rtl/instruction_fetch_unit_if.sv
// Bundle of the instruction-memory read port, redirect input and the
// decode-side valid/ready handshake of the fetch stage.
interface instruction_fetch_unit_if;

    logic [31:0] imem_pc;
    logic [31:0] imem_inst;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_inst;
    logic [31:0] id_pc;
    logic        fetch_fault;

    modport master (
        output imem_pc,
        input  imem_inst,
        input  redirect_valid,
        input  redirect_pc,
        output id_valid,
        input  id_ready,
        output id_inst,
        output id_pc,
        output fetch_fault
    );

    modport slave (
        input  imem_pc,
        output imem_inst,
        output redirect_valid,
        output redirect_pc,
        input  id_valid,
        output id_ready,
        input  id_inst,
        input  id_pc,
        input  fetch_fault
    );

endinterface

// File: rtl/fetch_queue.sv
// Small synchronous FIFO of (instruction, PC) pairs.
// Flush wins over push and pop; depth must be a power of two (2 or 4).
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_push,
    input  logic         i_pop,
    input  logic         i_flush,
    input  fetch_entry_t i_data,
    output logic         o_full,
    output logic         o_empty,
    output fetch_entry_t o_head
);

    localparam int PW = $clog2(DEPTH);

    if (!(DEPTH == 2 || DEPTH == 4)) begin : g_bad_depth
        $error("fetch_queue: DEPTH must be 2 or 4");
    end

    fetch_entry_t r_mem [DEPTH];
    logic [PW-1:0] r_rd;
    logic [PW-1:0] r_wr;
    logic [PW:0]   r_count;

    logic w_do_push;
    logic w_do_pop;

    assign o_full    = (r_count == (PW+1)'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_head    = r_mem[r_rd];
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);

    // Storage array: written at the tail on every accepted push.
    always_ff @(posedge clk) begin
        if (w_do_push && !i_flush) begin
            r_mem[r_wr] <= i_data;
        end
    end

    // Pointers and occupancy; reset and flush both empty the queue.
    always_ff @(posedge clk) begin
        if (rst || i_flush) begin
            r_rd    <= '0;
            r_wr    <= '0;
            r_count <= '0;
        end else begin
            if (w_do_push) begin
                r_wr <= r_wr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd <= r_rd + 1'b1;
            end
            r_count <= r_count
                     + {{PW{1'b0}}, w_do_push}
                     - {{PW{1'b0}}, w_do_pop};
        end
    end

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: drives the PC to instruction memory, queues the returned
// words for decode, and handles redirects and misaligned-target halts.
module instruction_fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = DEFAULT_RESET_PC,
    parameter int          QUEUE_DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    instruction_fetch_unit_if.master bus
);

    fetch_state_e r_state;
    fetch_state_e w_state_nxt;
    logic [31:0]  r_fetch_pc;
    logic [31:0]  w_pc_nxt;
    logic         r_fault;
    logic         w_fault_nxt;

    logic         w_push;
    logic         w_pop;
    logic         w_flush;
    logic         w_full;
    logic         w_empty;
    fetch_entry_t w_entry;
    fetch_entry_t w_head;

    assign bus.imem_pc     = r_fetch_pc;
    assign bus.id_valid    = !w_empty && (r_state == RUN);
    assign bus.id_inst     = w_head.inst;
    assign bus.id_pc       = w_head.pc;
    assign bus.fetch_fault = r_fault;

    assign w_flush      = bus.redirect_valid;
    assign w_pop        = bus.id_valid && bus.id_ready && !w_flush;
    assign w_entry.inst = bus.imem_inst;
    assign w_entry.pc   = r_fetch_pc;

    // State, PC and fault registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= RUN;
            r_fetch_pc <= RESET_PC;
            r_fault    <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_fetch_pc <= w_pc_nxt;
            r_fault    <= w_fault_nxt;
        end
    end

    // Next state: redirect first, otherwise sequential fetch while running.
    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_fetch_pc;
        w_fault_nxt = r_fault;
        w_push      = 1'b0;
        if (bus.redirect_valid) begin
            if (is_aligned(bus.redirect_pc)) begin
                w_state_nxt = RUN;
                w_pc_nxt    = bus.redirect_pc;
                w_fault_nxt = 1'b0;
            end else begin
                w_state_nxt = HALT;
                w_pc_nxt    = {bus.redirect_pc[31:2], 2'b00};
                w_fault_nxt = 1'b1;
            end
        end else begin
            unique case (r_state)
                RUN: begin
                    if (!w_full || w_pop) begin
                        w_push   = 1'b1;
                        w_pc_nxt = r_fetch_pc + 32'd4;
                    end
                end
                HALT: begin
                    w_push = 1'b0;
                end
                default: begin
                    w_state_nxt = RUN;
                end
            endcase
        end
    end

    fetch_queue #(
        .DEPTH (QUEUE_DEPTH)
    ) u_queue (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_flush (w_flush),
        .i_data  (w_entry),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_head  (w_head)
    );

endmodule
